// File: rtl/spinn_aer2_pkg.sv
// Shared SpiNNaker AER definitions: packet width, dump timeout default and round-robin helper.
package spinn_aer2_pkg;

    localparam int unsigned SPINN_PKT_WIDTH  = 72;
    localparam int unsigned DUMP_CYCLES_DFLT = 128;
    localparam int unsigned RR_MAX_PORTS     = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_result_t;

    typedef enum logic {
        ST_NORMAL,
        ST_DUMP
    } dump_state_t;

    // Search last+1 .. last+num (mod num); the first requester found wins.
    function automatic rr_result_t rr_next(input logic [RR_MAX_PORTS-1:0] req,
                                           input logic [2:0]              last,
                                           input int unsigned             num);
        rr_result_t  res;
        int unsigned pos;
        res = '0;
        for (int unsigned i = 1; i <= RR_MAX_PORTS; i++) begin
            if (i <= num) begin
                pos = 32'(last) + i;
                if (pos >= num) pos = pos - num;
                if (!res.found && req[pos[2:0]]) begin
                    res.found = 1'b1;
                    res.idx   = pos[2:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Reusable round-robin arbiter: combinational grant from req, pointer advances only on accepted grants.
module rr_arbiter
    import spinn_aer2_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         req,
    input  logic                         advance,
    output logic [$clog2(NUM_PORTS)-1:0] grant,
    output logic                         found
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [IDX_W-1:0]        last_grant;
    logic [RR_MAX_PORTS-1:0] req_ext;
    rr_result_t              res;

    assign req_ext = RR_MAX_PORTS'(req);
    assign res     = rr_next(req_ext, 3'(last_grant), NUM_PORTS);
    assign found   = res.found;
    assign grant   = IDX_W'(res.idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDX_W'(NUM_PORTS - 1);
        end else if (advance) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/ipkt_arbiter.sv
// Round-robin merge of in-mapper packet streams into one registered SpiNNaker output with dump mode.
// Optional drop counter enabled by defining IPKT_ARB_DROP_CNT_EN.
module ipkt_arbiter
    import spinn_aer2_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned PKT_WIDTH   = SPINN_PKT_WIDTH,
    parameter int unsigned DUMP_CYCLES = DUMP_CYCLES_DFLT,
    parameter int unsigned CTR_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*PKT_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]           in_vld,
    output logic [NUM_PORTS-1:0]           in_rdy,
    output logic [PKT_WIDTH-1:0]           out_data,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [$clog2(NUM_PORTS)-1:0]   grant_id,
    output logic                           dump_mode
`ifdef IPKT_ARB_DROP_CNT_EN
    ,
    output logic [CTR_WIDTH-1:0]           drop_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > RR_MAX_PORTS || DUMP_CYCLES < 1 || DUMP_CYCLES > 255
        || CTR_WIDTH < 1) begin : g_bad_cfg
        $error("ipkt_arbiter: parameter out of range");
    end

    dump_state_t      state, state_nxt;
    logic [7:0]       dump_ctr, dump_ctr_nxt;
    logic             load_en;
    logic             take;
    logic             arb_found;
    logic [IDX_W-1:0] arb_grant;

    assign dump_mode = (state == ST_DUMP);
    assign load_en   = ~out_vld | out_rdy;
    assign take      = ~rst & ~dump_mode & load_en & arb_found;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (in_vld),
        .advance (take),
        .grant   (arb_grant),
        .found   (arb_found)
    );

    // Dump mode accepts everything so upstream never backs up while SpiNNaker is stuck.
    always_comb begin
        in_rdy = '0;
        if (!rst) begin
            if (dump_mode) begin
                in_rdy = in_vld;
            end else if (take) begin
                in_rdy[arb_grant] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            grant_id <= '0;
        end else if (take) begin
            out_vld  <= 1'b1;
            out_data <= in_data[32'(arb_grant)*PKT_WIDTH +: PKT_WIDTH];
            grant_id <= arb_grant;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

    always_comb begin
        state_nxt    = state;
        dump_ctr_nxt = dump_ctr;
        if (out_rdy) begin
            dump_ctr_nxt = 8'(DUMP_CYCLES);
            state_nxt    = ST_NORMAL;
        end else if (dump_ctr != 8'd0) begin
            dump_ctr_nxt = dump_ctr - 8'd1;
        end else begin
            state_nxt    = ST_DUMP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_NORMAL;
            dump_ctr <= 8'(DUMP_CYCLES);
        end else begin
            state    <= state_nxt;
            dump_ctr <= dump_ctr_nxt;
        end
    end

`ifdef IPKT_ARB_DROP_CNT_EN
    localparam int unsigned SUM_W = CTR_WIDTH + 1;

    logic [SUM_W-1:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt} + SUM_W'($countones(in_vld));

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (dump_mode) begin
            drop_cnt <= drop_sum[CTR_WIDTH] ? '1 : drop_sum[CTR_WIDTH-1:0];
        end
    end
`endif

endmodule
